// File: rtl/temp_status_controller.sv
// Purpose: thermostat FSM that drives the heater or cooler around a setpoint, using hysteresis, dwell and fault handling.
// Latency: a sample is registered on temp_valid, and the state reacts one cycle later. All outputs are registered.
// Backpressure: none. temp_valid and clear_error are single-cycle pulses that are always accepted.
module temp_status_controller #(
    parameter int HYST      = 2,
    parameter int MIN_DWELL = 50_000_000,
    parameter int TIMEOUT   = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    input  logic [7:0] setpoint,
    input  logic       clear_error,
    output logic [1:0] status,
    output logic       heater_on,
    output logic       cooler_on,
    output logic       state_change
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10,
        ERROR   = 2'b11
    } state_t;

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT);
    localparam logic [8:0]    HYST9     = 9'(HYST);

    state_t        state;
    state_t        next_state;
    logic [7:0]    temp_q;
    logic [WW-1:0] wd_cnt;
    logic [DW-1:0] dwell_cnt;

    logic [8:0] sp9;
    logic [8:0] tq9;
    logic [8:0] sum9;
    logic [8:0] low9;
    logic [8:0] high9;
    logic       wd_fault;
    logic       sensor_fault;
    logic       fault;
    logic       exit_fault;
    logic       dwell_done;
    logic       leaving_error;

    // Hysteresis thresholds in 9 bits. They saturate so they never wrap past the ends of the sensor range.
    always_comb begin
        sp9   = {1'b0, setpoint};
        tq9   = {1'b0, temp_q};
        sum9  = sp9 + HYST9;
        low9  = (sp9 >= HYST9) ? (sp9 - HYST9) : 9'd0;
        high9 = (sum9 > 9'd255) ? 9'd255 : sum9;
    end

    // Fault sources. When a new sample arrives in the same cycle as clear_error, the ERROR exit judges that
    // incoming sample, and it does not judge the stale capture or the watchdog it is about to reset.
    always_comb begin
        wd_fault      = (wd_cnt == WD_MAX);
        sensor_fault  = (temp_q == 8'h00) || (temp_q == 8'hFF);
        fault         = wd_fault || sensor_fault;
        exit_fault    = temp_valid ? ((temp == 8'h00) || (temp == 8'hFF)) : fault;
        dwell_done    = (dwell_cnt == DWELL_MAX);
        leaving_error = (state == ERROR) && (next_state != ERROR);
    end

    // Next-state logic. Priority order: fault first, then loss of enable, then the temperature thresholds.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fault)
                    next_state = ERROR;
                else if (enable && dwell_done && (tq9 < low9))
                    next_state = HEATING;
                else if (enable && dwell_done && (tq9 > high9))
                    next_state = COOLING;
            end
            HEATING: begin
                if (fault)
                    next_state = ERROR;
                else if (!enable)
                    next_state = IDLE;
                else if (dwell_done && (temp_q >= setpoint))
                    next_state = IDLE;
            end
            COOLING: begin
                if (fault)
                    next_state = ERROR;
                else if (!enable)
                    next_state = IDLE;
                else if (dwell_done && (temp_q <= setpoint))
                    next_state = IDLE;
            end
            ERROR: begin
                if (clear_error && !exit_fault)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and registered outputs. Reset drops the actuators asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            heater_on    <= 1'b0;
            cooler_on    <= 1'b0;
            state_change <= 1'b0;
        end else begin
            state        <= next_state;
            heater_on    <= (next_state == HEATING);
            cooler_on    <= (next_state == COOLING);
            state_change <= (next_state != state);
        end
    end

    assign status = state;

    // Sample capture. The reset value sits mid-range so that it trips neither fault nor threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            temp_q <= 8'h80;
        else if (temp_valid)
            temp_q <= temp;
    end

    // Sensor watchdog. It restarts on every sample and on leaving ERROR, and it parks at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (temp_valid || leaving_error)
            wd_cnt <= '0;
        else if (wd_cnt != WD_MAX)
            wd_cnt <= wd_cnt + WW'(1);
    end

    // Dwell timer. It restarts on every state entry and parks once the minimum dwell is reached.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dwell_cnt <= '0;
        else if (next_state != state)
            dwell_cnt <= '0;
        else if (dwell_cnt != DWELL_MAX)
            dwell_cnt <= dwell_cnt + DW'(1);
    end

endmodule

// File: doc/temp_status_controller.md
TEMP_STATUS_CONTROLLER -- requirements
Module: temp_status_controller

Interface
REQ-001 SHALL have parameter HYST, default 2, meaning hysteresis band in sensor LSBs.
REQ-002 SHALL have parameter MIN_DWELL, default 50_000_000, meaning the minimum cycles spent in a state before any non-fault transition.
REQ-003 SHALL have parameter TIMEOUT, default 100_000_000, meaning the maximum cycles allowed between temp_valid pulses.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: high permits heating or cooling.
REQ-007 SHALL have port temp, input, 8 bits: unsigned sensor reading.
REQ-008 SHALL have port temp_valid, input, 1 bit: one-cycle pulse qualifying temp.
REQ-009 SHALL have port setpoint, input, 8 bits: unsigned target temperature.
REQ-010 SHALL have port clear_error, input, 1 bit: one-cycle pulse requesting exit from ERROR.
REQ-011 SHALL have port status, output, 2 bits, encoded as: 00 idle, 01 heating, 10 cooling, 11 error (display status encoding).
REQ-012 SHALL have ports heater_on and cooler_on, outputs, 1 bit each: actuator drives.
REQ-013 SHALL have port state_change, output, 1 bit: one-cycle pulse on every state transition.

Function
REQ-014 SHALL implement FSM states IDLE, HEATING, COOLING, ERROR; status SHALL be the registered state code, and all outputs SHALL be registered.
REQ-015 SHALL capture temp into temp_q on any cycle with temp_valid high; all comparisons use temp_q, giving a transition at the earliest 1 cycle after temp_valid.
REQ-016 SHALL compute low = setpoint - HYST saturating at 0, and high = setpoint + HYST saturating at 255, in 9-bit unsigned arithmetic.
REQ-017 Watchdog: counter cleared on temp_valid, otherwise increments, saturating at TIMEOUT; a fault SHALL be raised when it equals TIMEOUT.
REQ-018 Sensor fault: a captured temp of 8'h00 or 8'hFF SHALL raise a fault.
REQ-019 Dwell counter SHALL clear on every state entry, increment each cycle, and saturate at MIN_DWELL.
REQ-020 Transition priority SHALL be: fault (any state to ERROR, ignoring dwell) > enable low (HEATING/COOLING to IDLE, ignoring dwell) > threshold rules.
REQ-021 IDLE to HEATING SHALL occur when temp_q < low, enable = 1, and dwell = MIN_DWELL.
REQ-022 IDLE to COOLING SHALL occur when temp_q > high, enable = 1, and dwell = MIN_DWELL.
REQ-023 HEATING to IDLE SHALL occur when temp_q >= setpoint and dwell = MIN_DWELL.
REQ-024 COOLING to IDLE SHALL occur when temp_q <= setpoint and dwell = MIN_DWELL.
REQ-025 There SHALL be no direct HEATING to COOLING or COOLING to HEATING transition; each passes through IDLE with a full dwell.
REQ-026 ERROR to IDLE SHALL occur only on clear_error with no fault present in the same cycle.
  - Leaving ERROR clears the watchdog.
  - clear_error outside ERROR is ignored.
REQ-027 heater_on SHALL equal (state == HEATING) and cooler_on SHALL equal (state == COOLING).
  - Both are never high together.
  - Both are low in ERROR.
REQ-028 state_change SHALL assert for exactly one cycle, in the same cycle status takes its new value.
REQ-029 temp_valid coincident with clear_error: the new sample SHALL be captured, and the fault check SHALL use the incoming temp value.

Reset
REQ-030 While reset_n is low, state = IDLE, status = 00, heater_on = 0, cooler_on = 0, state_change = 0, and temp_q = setpoint-neutral 8'h80.
  - Watchdog and dwell counters SHALL be held at 0.
REQ-031 Reset asserted mid-HEATING or mid-COOLING SHALL drop the actuators asynchronously, with no waiting for a clock edge.
REQ-032 After reset release, a full MIN_DWELL SHALL elapse before leaving IDLE.

Verification (HYST=2, MIN_DWELL=4, TIMEOUT=100)
REQ-033 Heating: setpoint=100, temp=97 valid, enable=1 after dwell -> status 01, heater_on=1, one state_change pulse; later temp=100 with dwell met -> status 00.
REQ-034 Hysteresis: setpoint=100, temp=98 -> stays IDLE; temp=103 -> COOLING; temp=101 -> stays COOLING; temp=100 -> IDLE.
REQ-035 Watchdog: no temp_valid for 100 cycles -> status 11, actuators 0; clear_error with no new sample -> remains 11; temp=100 valid then clear_error -> status 00.
REQ-036 Sensor fault: temp=8'hFF valid while HEATING -> ERROR on the next cycle regardless of dwell; temp=0 likewise.
REQ-037 Enable drop and no-reversal: enable=0 in HEATING -> IDLE next cycle; with enable high, temp jumping 95 to 110 -> HEATING, IDLE, COOLING, each separated by at least 4 cycles.
REQ-038 Saturation and reset: setpoint=1, temp=1 -> low=0, so never HEATING; setpoint=254 -> high=255, so never COOLING; reset_n low mid-COOLING -> cooler_on=0 immediately.
